// File: rtl/div_sequencer_pkg.sv
// Shared constants, FSM state type and func3 decode helpers for the RV32M divide sequencer.
package div_sequencer_pkg;

   localparam int DIV_XLEN = 32;

   localparam logic [2:0] FUNC3_DIV  = 3'b100;
   localparam logic [2:0] FUNC3_DIVU = 3'b101;
   localparam logic [2:0] FUNC3_REM  = 3'b110;
   localparam logic [2:0] FUNC3_REMU = 3'b111;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'b00,
      DIV_CALC = 2'b01,
      DIV_FIX  = 2'b10,
      DIV_DONE = 2'b11
   } div_state_e;

   function automatic logic is_div_op(input logic [2:0] f);
      return (f == FUNC3_DIV) || (f == FUNC3_DIVU) || (f == FUNC3_REM) || (f == FUNC3_REMU);
   endfunction

   function automatic logic is_signed_op(input logic [2:0] f);
      return (f == FUNC3_DIV) || (f == FUNC3_REM);
   endfunction

   function automatic logic is_rem_op(input logic [2:0] f);
      return (f == FUNC3_REM) || (f == FUNC3_REMU);
   endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// EX-stage <-> divide sequencer handshake: operands and abort in, stall/done/result out.
interface div_sequencer_if #(
   parameter int XLEN = div_sequencer_pkg::DIV_XLEN
);
   logic            start;
   logic [2:0]      func3;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic            flush;
   logic            stall;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output start, func3, rs1_data, rs2_data, flush,
      input  stall, done, result
   );

   modport slave (
      input  start, func3, rs1_data, rs2_data, flush,
      output stall, done, result
   );
endinterface

// File: rtl/div_sequencer_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_sequencer_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rem_in,
   input  logic            dvd_msb,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] rem_out,
   output logic            q_bit
);
   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;

   // Extra bit keeps 2*rem+1 exact when the divisor is >= 2^(XLEN-1).
   assign shifted = {rem_in, dvd_msb};
   assign diff    = shifted - {1'b0, divisor};
   assign q_bit   = ~diff[XLEN];
   assign rem_out = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU sequencer: radix-2 restoring divide with
// one-cycle special cases, pipeline stall and a one-cycle done pulse.
module div_sequencer
   import div_sequencer_pkg::*;
#(
   parameter int XLEN = DIV_XLEN
) (
   input logic            clk,
   input logic            rst_n,
   div_sequencer_if.slave bus
);
   localparam int CW = $clog2(XLEN + 1);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   div_state_e state_reg, state_next;

   logic [CW-1:0]   counter_reg;
   logic [2:0]      func3_reg;
   logic            sign1_reg, sign2_reg;
   logic [XLEN-1:0] dvd_reg, divisor_reg, quo_reg, rem_reg, result_reg;

   logic            accept, signed_in, div_by_zero, overflow, special;
   logic [XLEN-1:0] abs1, abs2, special_result, quo_fix, rem_fix, step_rem;
   logic            q_bit, signed_fix;

   assign accept      = bus.start & ~bus.flush & is_div_op(bus.func3);
   assign signed_in   = is_signed_op(bus.func3);
   assign div_by_zero = (bus.rs2_data == '0);
   assign overflow    = signed_in & (bus.rs1_data == MIN_NEG) & (&bus.rs2_data);
   assign special     = div_by_zero | overflow;

   assign abs1 = (signed_in & bus.rs1_data[XLEN-1]) ? -bus.rs1_data : bus.rs1_data;
   assign abs2 = (signed_in & bus.rs2_data[XLEN-1]) ? -bus.rs2_data : bus.rs2_data;

   always_comb begin
      special_result = '0;
      if (div_by_zero)
         special_result = is_rem_op(bus.func3) ? bus.rs1_data : '1;
      else
         special_result = is_rem_op(bus.func3) ? '0 : bus.rs1_data;
   end

   // Quotient sign is the XOR of operand signs; remainder follows the dividend.
   assign signed_fix = is_signed_op(func3_reg);
   assign quo_fix    = (signed_fix & (sign1_reg ^ sign2_reg)) ? -quo_reg : quo_reg;
   assign rem_fix    = (signed_fix & sign1_reg) ? -rem_reg : rem_reg;

   div_sequencer_step #(.XLEN(XLEN)) u_step (
      .rem_in  (rem_reg),
      .dvd_msb (dvd_reg[XLEN-1]),
      .divisor (divisor_reg),
      .rem_out (step_rem),
      .q_bit   (q_bit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_reg <= DIV_IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      if (bus.flush) begin
         state_next = DIV_IDLE;
      end else begin
         case (state_reg)
            DIV_IDLE: if (accept) state_next = special ? DIV_DONE : DIV_CALC;
            DIV_CALC: if (counter_reg == CW'(1)) state_next = DIV_FIX;
            DIV_FIX:  state_next = DIV_DONE;
            DIV_DONE: state_next = DIV_IDLE;
            default:  state_next = DIV_IDLE;
         endcase
      end
   end

   assign bus.stall  = ((state_reg == DIV_IDLE) & accept) | (state_reg == DIV_CALC)
                     | (state_reg == DIV_FIX);
   assign bus.done   = (state_reg == DIV_DONE);
   assign bus.result = result_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         counter_reg <= '0;
         func3_reg   <= '0;
         sign1_reg   <= 1'b0;
         sign2_reg   <= 1'b0;
         dvd_reg     <= '0;
         divisor_reg <= '0;
         quo_reg     <= '0;
         rem_reg     <= '0;
         result_reg  <= '0;
      end else if (!bus.flush) begin
         case (state_reg)
            DIV_IDLE: begin
               if (accept) begin
                  if (special) begin
                     result_reg <= special_result;
                  end else begin
                     func3_reg   <= bus.func3;
                     sign1_reg   <= signed_in & bus.rs1_data[XLEN-1];
                     sign2_reg   <= signed_in & bus.rs2_data[XLEN-1];
                     dvd_reg     <= abs1;
                     divisor_reg <= abs2;
                     quo_reg     <= '0;
                     rem_reg     <= '0;
                     counter_reg <= CW'(XLEN);
                  end
               end
            end
            DIV_CALC: begin
               rem_reg     <= step_rem;
               dvd_reg     <= {dvd_reg[XLEN-2:0], 1'b0};
               quo_reg     <= {quo_reg[XLEN-2:0], q_bit};
               counter_reg <= counter_reg - CW'(1);
            end
            DIV_FIX: begin
               result_reg <= is_rem_op(func3_reg) ? rem_fix : quo_fix;
            end
            default: ;
         endcase
      end
   end
endmodule
